// File: rtl/ps2_scancode_decoder_if.sv
// Pad inputs and single-cycle editing events between the PS/2 front end and input_buffer.
// PS2_SCANCODE_DECODER_PARITY_CHECK_EN adds the parity_error event.
interface ps2_scancode_decoder_if #(
    parameter int SYMBOL_WIDTH = 7
);
    logic                    ps2_clk;
    logic                    ps2_dat;
    logic                    left;
    logic                    right;
    logic                    backspace;
    logic [SYMBOL_WIDTH-1:0] symbol;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
    logic                    parity_error;

    modport master (input ps2_clk, ps2_dat, output left, right, backspace, symbol, parity_error);
    modport slave  (output ps2_clk, ps2_dat, input left, right, backspace, symbol, parity_error);
`else
    modport master (input ps2_clk, ps2_dat, output left, right, backspace, symbol);
    modport slave  (output ps2_clk, ps2_dat, input left, right, backspace, symbol);
`endif
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard receiver and scan code set 2 decoder producing editing events and ASCII symbols.
// Optional frame validation is enabled by PS2_SCANCODE_DECODER_PARITY_CHECK_EN.
module ps2_scancode_decoder #(
    parameter int SYMBOL_WIDTH   = 7,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_scancode_decoder_if.master bus
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_meta_reg, clk_sync_reg, dat_meta_reg, dat_sync_reg;
    logic [FW-1:0] filt_cnt_reg;
    logic          filt_clk_reg, filt_prev_reg;
    logic          fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_reg  <= 1'b1;
            clk_sync_reg  <= 1'b1;
            dat_meta_reg  <= 1'b1;
            dat_sync_reg  <= 1'b1;
            filt_cnt_reg  <= '0;
            filt_clk_reg  <= 1'b1;
            filt_prev_reg <= 1'b1;
        end else begin
            clk_meta_reg  <= bus.ps2_clk;
            clk_sync_reg  <= clk_meta_reg;
            dat_meta_reg  <= bus.ps2_dat;
            dat_sync_reg  <= dat_meta_reg;
            filt_prev_reg <= filt_clk_reg;
            // The filtered level only follows after FILTER_CYCLES consecutive disagreeing samples.
            if (clk_sync_reg == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_CYCLES - 1)) begin
                filt_clk_reg <= clk_sync_reg;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign fall = filt_prev_reg & ~filt_clk_reg;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    sr_reg, sr_next;
    logic [7:0]    byte_reg, byte_next;
    logic [TW-1:0] to_reg, to_next;
    logic          byte_valid_reg, byte_valid_next;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
    logic          par_reg, par_next;
    logic          perr_stage_reg, perr_stage_next;
    logic          parity_error_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            sr_reg         <= '0;
            byte_reg       <= '0;
            to_reg         <= '0;
            byte_valid_reg <= 1'b0;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
            par_reg          <= 1'b0;
            perr_stage_reg   <= 1'b0;
            parity_error_reg <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            sr_reg         <= sr_next;
            byte_reg       <= byte_next;
            to_reg         <= to_next;
            byte_valid_reg <= byte_valid_next;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
            par_reg          <= par_next;
            perr_stage_reg   <= perr_stage_next;
            parity_error_reg <= perr_stage_reg;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        sr_next         = sr_reg;
        byte_next       = byte_reg;
        to_next         = to_reg;
        byte_valid_next = 1'b0;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
        par_next        = par_reg;
        perr_stage_next = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                to_next = '0;
                if (fall && !dat_sync_reg) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: if (fall) begin
                sr_next      = {dat_sync_reg, sr_reg[7:1]};
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) state_next = PARITY;
            end
            PARITY: if (fall) begin
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
                par_next   = dat_sync_reg;
`endif
                state_next = STOP;
            end
            STOP: if (fall) begin
                state_next = IDLE;
                byte_next  = sr_reg;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
                if ((^{sr_reg, par_reg}) && dat_sync_reg) byte_valid_next = 1'b1;
                else                                      perr_stage_next = 1'b1;
`else
                byte_valid_next = 1'b1;
`endif
            end
            default: state_next = IDLE;
        endcase
        // A stalled keyboard mid-frame drops the partial byte.
        if (state_reg != IDLE) begin
            if (fall)                                   to_next = '0;
            else if (to_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next = IDLE;
                to_next    = '0;
            end else                                    to_next = to_reg + 1'b1;
        end
    end

    function automatic logic [7:0] plain_map(input logic [7:0] code, input logic shifted);
        logic [7:0] s;
        s = 8'h00;
        case (code)
            8'h45: s = shifted ? 8'h29 : 8'h30;
            8'h16: s = shifted ? 8'h00 : 8'h31;
            8'h1E: s = shifted ? 8'h00 : 8'h32;
            8'h26: s = shifted ? 8'h00 : 8'h33;
            8'h25: s = shifted ? 8'h00 : 8'h34;
            8'h2E: s = shifted ? 8'h00 : 8'h35;
            8'h36: s = shifted ? 8'h5E : 8'h36;
            8'h3D: s = shifted ? 8'h00 : 8'h37;
            8'h3E: s = shifted ? 8'h2A : 8'h38;
            8'h46: s = shifted ? 8'h28 : 8'h39;
            8'h22: s = 8'h78;
            8'h4E: s = 8'h2D;
            8'h55: s = shifted ? 8'h2B : 8'h00;
            8'h4A: s = 8'h2F;
            8'h49: s = 8'h2E;
            8'h79: s = 8'h2B;
            8'h7C: s = 8'h2A;
            8'h7B: s = 8'h2D;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    logic                    ext_reg, ext_next, brk_reg, brk_next, shift_reg, shift_next;
    logic                    left_reg, left_next, right_reg, right_next, bs_reg, bs_next;
    logic [SYMBOL_WIDTH-1:0] symbol_reg, symbol_next;
    logic [7:0]              sym8;

    always_comb begin
        ext_next   = ext_reg;
        brk_next   = brk_reg;
        shift_next = shift_reg;
        left_next  = 1'b0;
        right_next = 1'b0;
        bs_next    = 1'b0;
        sym8       = 8'h00;
        if (byte_valid_reg) begin
            if (byte_reg == 8'hE0) begin
                ext_next = 1'b1;
            end else if (byte_reg == 8'hF0) begin
                brk_next = 1'b1;
            end else begin
                ext_next = 1'b0;
                brk_next = 1'b0;
                if (!ext_reg && (byte_reg == 8'h12 || byte_reg == 8'h59)) begin
                    shift_next = !brk_reg;
                end else if (!brk_reg) begin
                    if (ext_reg) begin
                        case (byte_reg)
                            8'h6B:   left_next  = 1'b1;
                            8'h74:   right_next = 1'b1;
                            8'h4A:   sym8       = 8'h2F;
                            default: ;
                        endcase
                    end else if (byte_reg == 8'h66) begin
                        bs_next = 1'b1;
                    end else begin
                        sym8 = plain_map(byte_reg, shift_reg);
                    end
                end
            end
        end
        symbol_next = SYMBOL_WIDTH'(sym8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_reg    <= 1'b0;
            brk_reg    <= 1'b0;
            shift_reg  <= 1'b0;
            left_reg   <= 1'b0;
            right_reg  <= 1'b0;
            bs_reg     <= 1'b0;
            symbol_reg <= '0;
        end else begin
            ext_reg    <= ext_next;
            brk_reg    <= brk_next;
            shift_reg  <= shift_next;
            left_reg   <= left_next;
            right_reg  <= right_next;
            bs_reg     <= bs_next;
            symbol_reg <= symbol_next;
        end
    end

    assign bus.left      = left_reg;
    assign bus.right     = right_reg;
    assign bus.backspace = bs_reg;
    assign bus.symbol    = symbol_reg;
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
    assign bus.parity_error = parity_error_reg;
`endif
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: frames are bit-banged on the pads and every
// output event is logged with its cycle, then compared against a vector table.
module tb_ps2_scancode_decoder;
    localparam int FILT = 8;
    localparam int TOUT = 5000;
    localparam int LAT  = 4 + FILT;  // 2 sync flops + filter + byte_valid + output register
    localparam int HALF = 20;

    localparam int K_NONE = 0, K_SYM = 1, K_LEFT = 2, K_RIGHT = 3, K_BS = 4, K_PERR = 5, K_MULTI = 9;

    typedef struct {
        int         nbytes;
        logic [7:0] b0, b1, b2;
        int         exp_kind;
        int         exp_val;
    } vec_t;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   last_stop_cyc = 0;
    int   total = 0;
    int   passed = 0;
    ev_t  ev_q[$];
    vec_t vecs[$];

    ps2_scancode_decoder_if #(.SYMBOL_WIDTH(7)) bus ();

    ps2_scancode_decoder #(
        .SYMBOL_WIDTH(7),
        .FILTER_CYCLES(FILT),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int nz;
        nz = 0;
        if (bus.symbol != 0) begin ev_q.push_back('{K_SYM, int'(bus.symbol), cyc}); nz++; end
        if (bus.left)        begin ev_q.push_back('{K_LEFT, 1, cyc}); nz++; end
        if (bus.right)       begin ev_q.push_back('{K_RIGHT, 1, cyc}); nz++; end
        if (bus.backspace)   begin ev_q.push_back('{K_BS, 1, cyc}); nz++; end
`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
        if (bus.parity_error) begin ev_q.push_back('{K_PERR, 1, cyc}); nz++; end
`endif
        if (nz > 1) ev_q.push_back('{K_MULTI, nz, cyc});
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop).
    task automatic send_frame(input logic [7:0] d, input int half, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (bad_par ? ^d : ~^d), d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_dat = bits[i];
            repeat (half) @(negedge clk);
            if (i == 10) last_stop_cyc = cyc;
            bus.ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_dat = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic expect_events(input string name, input int kind, input int val);
        repeat (30) @(negedge clk);
        if (kind == K_NONE) begin
            check({name, " event count"}, ev_q.size(), 0);
        end else begin
            check({name, " event count"}, ev_q.size(), 1);
            if (ev_q.size() == 1) begin
                check({name, " kind"}, ev_q[0].kind, kind);
                check({name, " value"}, ev_q[0].val, val);
                check({name, " latency"}, ev_q[0].cyc - last_stop_cyc, LAT);
            end
        end
        ev_q.delete();
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input int k, input int v);
        vec_t r;
        r.nbytes = n; r.b0 = a; r.b1 = b; r.b2 = c; r.exp_kind = k; r.exp_val = v;
        return r;
    endfunction

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;

        vecs.push_back(mk(2, 8'hF0, 8'h16, 8'h00, K_NONE, 0));
        vecs.push_back(mk(2, 8'hE0, 8'h6B, 8'h00, K_LEFT, 1));
        vecs.push_back(mk(3, 8'hE0, 8'hF0, 8'h6B, K_NONE, 0));
        vecs.push_back(mk(1, 8'h66, 8'h00, 8'h00, K_BS, 1));
        vecs.push_back(mk(2, 8'hE0, 8'h74, 8'h00, K_RIGHT, 1));
        vecs.push_back(mk(1, 8'h12, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h46, 8'h00, 8'h00, K_SYM, 8'h28));
        vecs.push_back(mk(1, 8'h45, 8'h00, 8'h00, K_SYM, 8'h29));
        vecs.push_back(mk(1, 8'h36, 8'h00, 8'h00, K_SYM, 8'h5E));
        vecs.push_back(mk(1, 8'h3E, 8'h00, 8'h00, K_SYM, 8'h2A));
        vecs.push_back(mk(1, 8'h55, 8'h00, 8'h00, K_SYM, 8'h2B));
        vecs.push_back(mk(1, 8'h16, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(2, 8'hF0, 8'h12, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h46, 8'h00, 8'h00, K_SYM, 8'h39));
        vecs.push_back(mk(1, 8'h3E, 8'h00, 8'h00, K_SYM, 8'h38));
        vecs.push_back(mk(1, 8'h55, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h79, 8'h00, 8'h00, K_SYM, 8'h2B));
        vecs.push_back(mk(1, 8'h7C, 8'h00, 8'h00, K_SYM, 8'h2A));
        vecs.push_back(mk(1, 8'h7B, 8'h00, 8'h00, K_SYM, 8'h2D));
        vecs.push_back(mk(2, 8'hE0, 8'h4A, 8'h00, K_SYM, 8'h2F));
        vecs.push_back(mk(1, 8'h4A, 8'h00, 8'h00, K_SYM, 8'h2F));
        vecs.push_back(mk(1, 8'h49, 8'h00, 8'h00, K_SYM, 8'h2E));
        vecs.push_back(mk(1, 8'h4E, 8'h00, 8'h00, K_SYM, 8'h2D));
        vecs.push_back(mk(1, 8'h1E, 8'h00, 8'h00, K_SYM, 8'h32));
        vecs.push_back(mk(1, 8'h1E, 8'h00, 8'h00, K_SYM, 8'h32));
        vecs.push_back(mk(1, 8'h1C, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(2, 8'hE0, 8'h12, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h26, 8'h00, 8'h00, K_SYM, 8'h33));
        vecs.push_back(mk(1, 8'h59, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h16, 8'h00, 8'h00, K_NONE, 0));
        vecs.push_back(mk(2, 8'hF0, 8'h59, 8'h00, K_NONE, 0));
        vecs.push_back(mk(1, 8'h3D, 8'h00, 8'h00, K_SYM, 8'h37));

        // Reset state
        repeat (5) @(negedge clk);
        check("reset symbol", int'(bus.symbol), 0);
        check("reset left", int'(bus.left), 0);
        check("reset right", int'(bus.right), 0);
        check("reset backspace", int'(bus.backspace), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        ev_q.delete();

        // Slow keyboard clock
        send_frame(8'h16, 1000, 1'b0, 11);
        expect_events("slow 0x16", K_SYM, 8'h31);

        foreach (vecs[vi]) begin
            send_frame(vecs[vi].b0, HALF, 1'b0, 11);
            if (vecs[vi].nbytes > 1) send_frame(vecs[vi].b1, HALF, 1'b0, 11);
            if (vecs[vi].nbytes > 2) send_frame(vecs[vi].b2, HALF, 1'b0, 11);
            expect_events($sformatf("vec%0d", vi), vecs[vi].exp_kind, vecs[vi].exp_val);
        end

        // Stalled frame after 5 data bits must time out
        send_frame(8'h45, HALF, 1'b0, 6);
        repeat (TOUT + 1000) @(negedge clk);
        check("timeout quiet", ev_q.size(), 0);
        send_frame(8'h45, HALF, 1'b0, 11);
        expect_events("after timeout 0x45", K_SYM, 8'h30);

        // Short clock glitches with data low must not start a frame
        bus.ps2_dat = 1'b0;
        for (int g = 0; g < 5; g++) begin
            bus.ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (12) @(negedge clk);
        end
        bus.ps2_dat = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h16, HALF, 1'b0, 11);
        expect_events("after glitches 0x16", K_SYM, 8'h31);

        // Reset mid-frame after an extended prefix
        send_frame(8'hE0, HALF, 1'b0, 11);
        send_frame(8'h22, HALF, 1'b0, 5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid-reset symbol", int'(bus.symbol), 0);
        check("mid-reset events", ev_q.size(), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h22, HALF, 1'b0, 11);
        expect_events("after reset 0x22", K_SYM, 8'h78);

`ifdef PS2_SCANCODE_DECODER_PARITY_CHECK_EN
        send_frame(8'h1E, HALF, 1'b1, 11);
        expect_events("bad parity 0x1E", K_PERR, 1);
        send_frame(8'h1E, HALF, 1'b0, 11);
        expect_events("good parity 0x1E", K_SYM, 8'h32);
        // A rejected E0 must not set the extended flag
        send_frame(8'hE0, HALF, 1'b1, 11);
        ev_q.delete();
        send_frame(8'h4A, HALF, 1'b0, 11);
        expect_events("rejected E0 then 4A", K_SYM, 8'h2F);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
